serial_magnitude_comparator: RTL and testbench
==============================================

// Module: serial_magnitude_comparator
// PURPOSE
//   Bit-serial N-bit magnitude comparator sequencer, one stage upstream of the 1-bit
//   comparator. Loads two WIDTH-bit operands and presents them to the 1-bit comparator
//   one bit pair per cycle, MSB first, on bit_a/bit_b. It takes back the comparator's
//   x (a>b), y (a==b) and z (a<b) flags and reduces them to one registered
//   gt/eq/lt result with a done pulse. It stops at the first differing bit.
// PARAMETERS
//   WIDTH  8  operand width in bits (>=1)
// PORTS
//   clk     in   1      single clock, rising edge
//   rst     in   1      asynchronous, active-high reset
//   start   in   1      request; accepted only in IDLE
//   a_in    in   WIDTH  operand A, sampled on accepted start
//   b_in    in   WIDTH  operand B, sampled on accepted start
//   bit_a   out  1      current A bit to 1-bit comparator (MSB of A shift reg)
//   bit_b   out  1      current B bit to 1-bit comparator (MSB of B shift reg)
//   cmp_x   in   1      comparator a>b flag (combinational return)
//   cmp_y   in   1      comparator a==b flag
//   cmp_z   in   1      comparator a<b flag
//   busy    out  1      high while in COMPARE
//   done    out  1      one-cycle pulse, result valid
//   gt      out  1      A > B, held until next accepted start
//   eq      out  1      A == B, held until next accepted start
//   lt      out  1      A < B, held until next accepted start
//   err     out  1      cmp_x/y/z not one-hot during compare, held until next start
// BEHAVIOUR
//   Reset (async, any time incl. mid-compare): state=IDLE; shift regs, bit counter,
//     busy, done, gt, eq, lt, err all 0. Hence bit_a=bit_b=0.
//   FSM IDLE -> COMPARE -> DONE -> IDLE.
//   IDLE: on start=1, load shift_a<=a_in, shift_b<=b_in, cnt<=WIDTH-1.
//     Clear gt/eq/lt/err. Go to COMPARE. start=0: stay.
//   COMPARE (busy=1): bit_a/bit_b are the shift-reg MSBs, driven from registers only.
//     Flags are evaluated in the same cycle:
//     - flags not one-hot (none or >1 set): err<=1, gt/eq/lt stay 0, go to DONE.
//     - cmp_x=1: gt<=1, go to DONE.
//     - cmp_z=1: lt<=1, go to DONE.
//     - cmp_y=1 and cnt==0: eq<=1, go to DONE.
//     - cmp_y=1 and cnt>0: shift both regs left by 1 (zero fill), cnt<=cnt-1, stay.
//   DONE: done=1 for exactly one cycle, busy=0. Always go to IDLE next.
//   start is ignored in COMPARE and DONE; operands are not re-sampled.
//   Latency: start accepted at edge T; k = 1 + (number of leading equal bit pairs),
//     capped at WIDTH. COMPARE spans cycles T+1..T+k. done is high in cycle T+k+1.
//     Min 2 cycles start->done; max WIDTH+1.
//   Exactly one of gt/eq/lt/err is 1 from done until the next accepted start.
//   gt/eq/lt/err are all 0 after reset and while busy.
//   Back-to-back: next start is accepted in the cycle after done (IDLE).
//   WIDTH=1: a single COMPARE cycle; done is at T+2.
// TESTING
//   1. WIDTH=8, a_in=0xA5, b_in=0xA5, start at T -> busy T+1..T+8, done@T+9, eq=1, gt=lt=err=0.
//   2. a_in=0x80, b_in=0x7F -> one COMPARE cycle (bit_a=1, bit_b=0), done@T+2, gt=1.
//   3. a_in=0x12, b_in=0x13 -> differs at LSB only, done@T+9, lt=1. Hold 5 idle cycles: lt stays 1.
//   4. start at T with 0x00/0xFF, start=1 again at T+1 with 0xFF/0x00 -> second ignored, lt=1.
//   5. a_in=0x55, b_in=0x55, assert rst at T+3 for 1 cycle -> all outputs 0 immediately, no done;
//      then start 0x01/0x00 -> done after 9 cycles, gt=1.
//   6. Comparator stub forces cmp_x=cmp_y=1 on the first compare cycle -> done@T+2, err=1,
//      gt=eq=lt=0. Next start with a good stub: err clears.

Source files
------------

// File: rtl/serial_magnitude_comparator.sv
// ============================================================================
// serial_magnitude_comparator
//
// Purpose:
//   Bit-serial magnitude comparator sequencer. It loads two WIDTH-bit operands
//   and presents them, MSB first, one bit pair per cycle to an external 1-bit
//   comparator. It takes back that comparator's x (a>b), y (a==b) and z (a<b)
//   flags and reduces them to one registered gt/eq/lt result with a done
//   pulse. The walk stops at the first differing bit pair.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request, accepted only while idle
//   a_in, b_in   operands, sampled when start is accepted
//   bit_a, bit_b current bit pair for the 1-bit comparator (shift-reg MSBs)
//   cmp_x/y/z    comparator return flags (a>b, a==b, a<b)
//   busy         high while bits are being compared
//   done         one-cycle pulse, result valid
//   gt, eq, lt   result, held until the next accepted start
//   err          comparator flags were not one-hot, held until next start
// ============================================================================
module serial_magnitude_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             bit_a,
    output logic             bit_b,
    input  logic             cmp_x,
    input  logic             cmp_y,
    input  logic             cmp_z,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             err
);

    // Counter must be at least one bit wide even when WIDTH is 1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_b_q, shift_b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             err_q, err_d;

    logic [2:0]       flags;
    logic             flags_one_hot;

    assign flags         = {cmp_x, cmp_y, cmp_z};
    assign flags_one_hot = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);

    // State and datapath registers; everything returns to zero on reset so
    // that bit_a/bit_b and all result flags are low straight away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_a_q <= '0;
            shift_b_q <= '0;
            cnt_q     <= '0;
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            cnt_q     <= cnt_d;
            gt_q      <= gt_d;
            eq_q      <= eq_d;
            lt_q      <= lt_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic. A malformed flag set takes priority over any
    // decision so that a broken comparator never produces a plausible result.
    always_comb begin
        state_d   = state_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        cnt_d     = cnt_q;
        gt_d      = gt_q;
        eq_d      = eq_q;
        lt_d      = lt_q;
        err_d     = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shift_a_d = a_in;
                    shift_b_d = b_in;
                    cnt_d     = CW'(WIDTH - 1);
                    gt_d      = 1'b0;
                    eq_d      = 1'b0;
                    lt_d      = 1'b0;
                    err_d     = 1'b0;
                    state_d   = COMPARE;
                end
            end
            COMPARE: begin
                if (!flags_one_hot) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (cmp_x) begin
                    gt_d    = 1'b1;
                    state_d = DONE;
                end else if (cmp_z) begin
                    lt_d    = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == '0) begin
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    // Shift rather than slice so WIDTH=1 stays legal.
                    shift_a_d = shift_a_q << 1;
                    shift_b_d = shift_b_q << 1;
                    cnt_d     = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bit_a = shift_a_q[WIDTH-1];
    assign bit_b = shift_b_q[WIDTH-1];
    assign busy  = (state_q == COMPARE);
    assign done  = (state_q == DONE);
    assign gt    = gt_q;
    assign eq    = eq_q;
    assign lt    = lt_q;
    assign err   = err_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// ============================================================================
// tb_serial_magnitude_comparator
//
// Bench for the bit-serial magnitude comparator sequencer, WIDTH=8. A small
// 1-bit comparator stub answers bit_a/bit_b combinationally; it can be
// switched into a broken mode that asserts x and y together.
// ============================================================================
module tb_serial_magnitude_comparator;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] aIn;
    logic [W-1:0] bIn;
    logic         bitA;
    logic         bitB;
    logic         cmpX;
    logic         cmpY;
    logic         cmpZ;
    logic         busy;
    logic         done;
    logic         gt;
    logic         eq;
    logic         lt;
    logic         err;
    logic         stubBad;

    int checks;
    int errors;

    serial_magnitude_comparator #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (aIn),
        .b_in  (bIn),
        .bit_a (bitA),
        .bit_b (bitB),
        .cmp_x (cmpX),
        .cmp_y (cmpY),
        .cmp_z (cmpZ),
        .busy  (busy),
        .done  (done),
        .gt    (gt),
        .eq    (eq),
        .lt    (lt),
        .err   (err)
    );

    // 100 MHz-style clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 1-bit comparator stub; broken mode raises x and y at once.
    always_comb begin
        cmpX = bitA & ~bitB;
        cmpY = ~(bitA ^ bitB);
        cmpZ = ~bitA & bitB;
        if (stubBad) begin
            cmpX = 1'b1;
            cmpY = 1'b1;
            cmpZ = 1'b0;
        end
    end

    // Drives one request starting in the current (idle) cycle and follows it
    // until done, with a bounded wait. doneCycle is -1 if done never arrived.
    task automatic runCompare(input logic [W-1:0] a, input logic [W-1:0] b,
                              output int doneCycle, output int busyCycles,
                              output logic firstA, output logic firstB,
                              output logic flagsWhileBusy);
        doneCycle      = -1;
        busyCycles     = 0;
        firstA         = 1'b0;
        firstB         = 1'b0;
        flagsWhileBusy = 1'b0;
        aIn   = a;
        bIn   = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 1) begin
                firstA = bitA;
                firstB = bitB;
            end
            if (done) begin
                doneCycle = c;
                break;
            end
            if (busy) begin
                busyCycles++;
                if (gt | eq | lt | err) flagsWhileBusy = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        start   = 1'b0;
        aIn     = '0;
        bIn     = '0;
        stubBad = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, bitA, bitB, gt, eq, lt, err} !== 8'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected 00000000",
                     {busy, done, bitA, bitB, gt, eq, lt, err});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, gt, eq, lt, err} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: got %b expected 000000",
                     {busy, done, gt, eq, lt, err});
        end
    endtask

    task automatic test_equal;
        int dc, bc;
        logic fa, fb, fw;
        runCompare(8'hA5, 8'hA5, dc, bc, fa, fb, fw);
        checks++;
        if (dc !== 9) begin
            errors++;
            $display("[TB] FAIL eq_done_cycle: got %0d expected 9", dc);
        end
        checks++;
        if (bc !== 8) begin
            errors++;
            $display("[TB] FAIL eq_busy_cycles: got %0d expected 8", bc);
        end
        checks++;
        if (fw !== 1'b0) begin
            errors++;
            $display("[TB] FAIL eq_flags_while_busy: got %b expected 0", fw);
        end
        checks++;
        if ({gt, eq, lt, err} !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL eq_result: got %b expected 0100", {gt, eq, lt, err});
        end
    endtask

    task automatic test_msb_differs;
        int dc, bc;
        logic fa, fb, fw;
        @(posedge clk); #1;
        runCompare(8'h80, 8'h7F, dc, bc, fa, fb, fw);
        checks++;
        if (dc !== 2) begin
            errors++;
            $display("[TB] FAIL msb_done_cycle: got %0d expected 2", dc);
        end
        checks++;
        if ({fa, fb} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL msb_first_bits: got %b expected 10", {fa, fb});
        end
        checks++;
        if ({gt, eq, lt, err} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL msb_result: got %b expected 1000", {gt, eq, lt, err});
        end
    endtask

    task automatic test_lsb_differs_hold;
        int dc, bc;
        logic fa, fb, fw;
        @(posedge clk); #1;
        runCompare(8'h12, 8'h13, dc, bc, fa, fb, fw);
        checks++;
        if (dc !== 9) begin
            errors++;
            $display("[TB] FAIL lsb_done_cycle: got %0d expected 9", dc);
        end
        checks++;
        if ({gt, eq, lt, err} !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL lsb_result: got %b expected 0010", {gt, eq, lt, err});
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({busy, done, gt, eq, lt, err} !== 6'b000010) begin
                errors++;
                $display("[TB] FAIL lsb_hold_%0d: got %b expected 000010", i,
                         {busy, done, gt, eq, lt, err});
            end
        end
    endtask

    task automatic test_start_ignored;
        aIn   = 8'h00;
        bIn   = 8'hFF;
        start = 1'b1;
        @(posedge clk); #1;
        aIn = 8'hFF;
        bIn = 8'h00;
        checks++;
        if ({busy, bitA, bitB} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL ignore_first_cycle: got %b expected 101", {busy, bitA, bitB});
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({done, gt, eq, lt, err} !== 5'b10010) begin
            errors++;
            $display("[TB] FAIL ignore_result: got %b expected 10010", {done, gt, eq, lt, err});
        end
        @(posedge clk); #1;
        checks++;
        if ({busy, done, gt, eq, lt, err} !== 6'b000010) begin
            errors++;
            $display("[TB] FAIL ignore_back_idle: got %b expected 000010",
                     {busy, done, gt, eq, lt, err});
        end
    endtask

    task automatic test_reset_mid_compare;
        int dc, bc;
        logic fa, fb, fw;
        int strayDone;
        aIn   = 8'h55;
        bIn   = 8'h55;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, bitA, bitB, gt, eq, lt, err} !== 8'b0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got %b expected 00000000",
                     {busy, done, bitA, bitB, gt, eq, lt, err});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        strayDone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (busy | done) strayDone++;
        end
        checks++;
        if (strayDone !== 0) begin
            errors++;
            $display("[TB] FAIL midreset_no_done: got %0d busy/done cycles expected 0", strayDone);
        end
        runCompare(8'h01, 8'h00, dc, bc, fa, fb, fw);
        checks++;
        if (dc !== 9) begin
            errors++;
            $display("[TB] FAIL midreset_next_done_cycle: got %0d expected 9", dc);
        end
        checks++;
        if ({gt, eq, lt, err} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL midreset_next_result: got %b expected 1000", {gt, eq, lt, err});
        end
    endtask

    task automatic test_bad_flags;
        int dc, bc;
        logic fa, fb, fw;
        @(posedge clk); #1;
        stubBad = 1'b1;
        runCompare(8'h33, 8'h33, dc, bc, fa, fb, fw);
        stubBad = 1'b0;
        checks++;
        if (dc !== 2) begin
            errors++;
            $display("[TB] FAIL err_done_cycle: got %0d expected 2", dc);
        end
        checks++;
        if ({gt, eq, lt, err} !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL err_result: got %b expected 0001", {gt, eq, lt, err});
        end
        @(posedge clk); #1;
        runCompare(8'h80, 8'h7F, dc, bc, fa, fb, fw);
        checks++;
        if ({gt, eq, lt, err} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL err_cleared_result: got %b expected 1000", {gt, eq, lt, err});
        end
    endtask

    task automatic test_back_to_back;
        int dc, bc;
        logic fa, fb, fw;
        @(posedge clk); #1;
        runCompare(8'h0F, 8'h0E, dc, bc, fa, fb, fw);
        checks++;
        if ({dc, gt, eq, lt, err} !== {32'd9, 4'b1000}) begin
            errors++;
            $display("[TB] FAIL b2b_first: got cycle %0d flags %b expected cycle 9 flags 1000",
                     dc, {gt, eq, lt, err});
        end
        // Next request lands in the idle cycle right after done.
        @(posedge clk); #1;
        runCompare(8'h3C, 8'h3C, dc, bc, fa, fb, fw);
        checks++;
        if ({dc, gt, eq, lt, err} !== {32'd9, 4'b0100}) begin
            errors++;
            $display("[TB] FAIL b2b_second: got cycle %0d flags %b expected cycle 9 flags 0100",
                     dc, {gt, eq, lt, err});
        end
        checks++;
        if (fw !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_flags_while_busy: got %b expected 0", fw);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        $display("[TB] serial_magnitude_comparator bench, WIDTH=%0d", W);
        test_reset();
        test_equal();
        test_msb_differs();
        test_lsb_differs_hold();
        test_start_ignored();
        test_reset_mid_compare();
        test_bad_flags();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
